// File: rtl/fyp_tx_pkg.sv
// fyp_tx_pkg: shared types and constants for the
// transmit scheduler slice.
package fyp_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SOP,
        ST_IN_PKT,
        ST_GAP
    } tx_state_t;

    localparam logic [1:0] MODE_CONT   = 2'd0;
    localparam logic [1:0] MODE_BURST  = 2'd1;
    localparam logic [1:0] MODE_SINGLE = 2'd2;

    localparam int DEF_CNT_W       = 32;
    localparam int DEF_GAP_W       = 16;
    localparam int DEF_WDOG_CYCLES = 4096;

endpackage

// File: rtl/fyp_cycle_timer.sv
// fyp_cycle_timer: loadable down-counter that
// parks at zero and flags expiry there.
module fyp_cycle_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         expired
);

    logic [W-1:0] count;

    // load wins over tick; never wraps below zero
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/fyp_tx_scheduler.sv
// fyp_tx_scheduler: paces gen_start/gen_stop per
// packet slot and watches the stream into the MAC.
module fyp_tx_scheduler
    import fyp_tx_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int GAP_W       = DEF_GAP_W,
    parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic             cfg_stop,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_pkt_count,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic             mon_valid,
    input  logic             mon_rdy,
    input  logic             mon_sop,
    input  logic             mon_eop,
    output logic             gen_start,
    output logic             gen_stop,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_count,
    output logic             err_timeout,
    output logic             err_proto
);

    localparam int WD_W = $clog2(WDOG_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(WDOG_CYCLES - 1);

    tx_state_t        state, state_n;
    logic             cont_q, cont_n;
    logic [CNT_W-1:0] target_q, target_n;
    logic [GAP_W-1:0] gap_q, gap_n;
    logic             stop_pend, stop_pend_n;
    logic             gen_start_n, gen_stop_n, done_n;
    logic             err_t_n, err_p_n;
    logic [CNT_W-1:0] sent_n, sent_inc;
    logic             acc, sop_a, eop_a;
    logic             complete, finish;
    logic             gap_load, gap_exp;
    logic             wd_load, wd_tick, wd_exp;
    logic             watching;

    assign acc      = mon_valid & mon_rdy;
    assign sop_a    = acc & mon_sop;
    assign eop_a    = acc & mon_eop;
    assign sent_inc = (&sent_count) ? sent_count
                                    : sent_count + 1'b1;
    assign finish   = (!cont_q && sent_inc == target_q)
                      || stop_pend || cfg_stop;
    assign watching = (state == ST_WAIT_SOP)
                      || (state == ST_IN_PKT);
    assign wd_tick  = watching;
    assign wd_load  = (acc && watching)
                      || (state_n == ST_WAIT_SOP
                          && state != ST_WAIT_SOP);

    fyp_cycle_timer #(.W(GAP_W)) u_gap_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (gap_load),
        .load_val (gap_q),
        .tick     (state == ST_GAP),
        .expired  (gap_exp)
    );

    fyp_cycle_timer #(.W(WD_W)) u_wdog_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (wd_load),
        .load_val (WD_LOAD),
        .tick     (wd_tick),
        .expired  (wd_exp)
    );

    // next state, pulses and counter/flag updates
    always_comb begin
        state_n     = state;
        cont_n      = cont_q;
        target_n    = target_q;
        gap_n       = gap_q;
        stop_pend_n = stop_pend;
        gen_start_n = 1'b0;
        gen_stop_n  = 1'b0;
        done_n      = 1'b0;
        sent_n      = sent_count;
        err_t_n     = err_timeout;
        err_p_n     = err_proto;
        complete    = 1'b0;
        gap_load    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cfg_start && !cfg_stop) begin
                    cont_n      = (cfg_mode == MODE_CONT);
                    target_n    = (cfg_mode == MODE_BURST)
                                  ? cfg_pkt_count : CNT_W'(1);
                    gap_n       = cfg_gap;
                    stop_pend_n = 1'b0;
                    sent_n      = '0;
                    err_t_n     = 1'b0;
                    err_p_n     = 1'b0;
                    if (cfg_mode == MODE_BURST
                        && cfg_pkt_count == '0) begin
                        done_n = 1'b1;
                    end else begin
                        gen_start_n = 1'b1;
                        state_n     = ST_WAIT_SOP;
                    end
                end
            end
            ST_WAIT_SOP: begin
                if (cfg_stop) begin
                    gen_stop_n = 1'b1;
                    done_n     = 1'b1;
                    state_n    = ST_IDLE;
                end else if (sop_a && eop_a) begin
                    complete = 1'b1;
                end else if (sop_a) begin
                    state_n = ST_IN_PKT;
                end else if (eop_a) begin
                    err_p_n = 1'b1;
                end else if (!acc && wd_exp) begin
                    err_t_n    = 1'b1;
                    gen_stop_n = 1'b1;
                    done_n     = 1'b1;
                    state_n    = ST_IDLE;
                end
            end
            ST_IN_PKT: begin
                if (cfg_stop) stop_pend_n = 1'b1;
                if (sop_a) err_p_n = 1'b1;
                if (eop_a) begin
                    complete = 1'b1;
                end else if (!acc && wd_exp) begin
                    err_t_n    = 1'b1;
                    gen_stop_n = 1'b1;
                    done_n     = 1'b1;
                    state_n    = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (eop_a) err_p_n = 1'b1;
                if (cfg_stop) begin
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end else if (gap_exp) begin
                    gen_start_n = 1'b1;
                    state_n     = ST_WAIT_SOP;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (complete) begin
            gen_stop_n = 1'b1;
            sent_n     = sent_inc;
            if (finish) begin
                done_n  = 1'b1;
                state_n = ST_IDLE;
            end else begin
                gap_load = 1'b1;
                state_n  = ST_GAP;
            end
        end
    end

    // state, latched config and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cont_q      <= 1'b0;
            target_q    <= '0;
            gap_q       <= '0;
            stop_pend   <= 1'b0;
            gen_start   <= 1'b0;
            gen_stop    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sent_count  <= '0;
            err_timeout <= 1'b0;
            err_proto   <= 1'b0;
        end else begin
            state       <= state_n;
            cont_q      <= cont_n;
            target_q    <= target_n;
            gap_q       <= gap_n;
            stop_pend   <= stop_pend_n;
            gen_start   <= gen_start_n;
            gen_stop    <= gen_stop_n;
            busy        <= (state_n != ST_IDLE);
            done        <= done_n;
            sent_count  <= sent_n;
            err_timeout <= err_t_n;
            err_proto   <= err_p_n;
        end
    end

endmodule

// File: tb/tb_fyp_tx_scheduler.sv
// tb_fyp_tx_scheduler: directed checks of pacing,
// stop handling, watchdog and protocol flags.
`timescale 1ns/1ps
module tb_fyp_tx_scheduler;
    import fyp_tx_pkg::*;

    localparam int CNT_W = 32;
    localparam int GAP_W = 16;
    localparam int WDOG  = 4096;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_start, cfg_stop;
    logic [1:0]       cfg_mode;
    logic [CNT_W-1:0] cfg_pkt_count;
    logic [GAP_W-1:0] cfg_gap;
    logic             mon_valid, mon_rdy, mon_sop, mon_eop;
    logic             gen_start, gen_stop, busy, done;
    logic [CNT_W-1:0] sent_count;
    logic             err_timeout, err_proto;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int starts = 0;
    int overlap = 0;
    int s0, m, n, b;
    bit ok;
    logic acc, last;

    fyp_tx_scheduler #(
        .CNT_W(CNT_W), .GAP_W(GAP_W), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_mode(cfg_mode), .cfg_pkt_count(cfg_pkt_count),
        .cfg_gap(cfg_gap),
        .mon_valid(mon_valid), .mon_rdy(mon_rdy),
        .mon_sop(mon_sop), .mon_eop(mon_eop),
        .gen_start(gen_start), .gen_stop(gen_stop),
        .busy(busy), .done(done), .sent_count(sent_count),
        .err_timeout(err_timeout), .err_proto(err_proto)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (gen_start) starts++;
        if (gen_start && gen_stop) overlap++;
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [1:0] mode,
                             input int cnt, input int gap);
        cfg_mode      = mode;
        cfg_pkt_count = CNT_W'(cnt);
        cfg_gap       = GAP_W'(gap);
        cfg_start     = 1'b1;
        step();
        cfg_start     = 1'b0;
    endtask

    task automatic send_pkt(input int len, output int eop_edge);
        for (int k = 0; k < len; k++) begin
            mon_valid = 1'b1;
            mon_sop   = (k == 0);
            mon_eop   = (k == len - 1);
            step();
        end
        eop_edge  = cyc;
        mon_valid = 1'b0;
        mon_sop   = 1'b0;
        mon_eop   = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int lim,
                              output bit found);
        found = 1'b0;
        for (int i = 0; i < lim && !found; i++) begin
            step();
            if (gen_start) found = 1'b1;
        end
        check(tag, found, 1);
    endtask

    initial begin
        reset = 1; cfg_start = 0; cfg_stop = 0;
        cfg_mode = 0; cfg_pkt_count = 0; cfg_gap = 0;
        mon_valid = 0; mon_rdy = 1; mon_sop = 0; mon_eop = 0;
        repeat (3) step();
        check("rst_gen_start", gen_start, 0);
        check("rst_gen_stop", gen_stop, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sent", sent_count, 0);
        check("rst_err_to", err_timeout, 0);
        check("rst_err_pr", err_proto, 0);
        reset = 0;
        step();

        // burst of 3, gap 5, 15-beat packets
        s0 = starts;
        start_run(MODE_BURST, 3, 5);
        check("t1_start", gen_start, 1);
        check("t1_busy", busy, 1);
        for (int p = 0; p < 3; p++) begin
            if (p > 0) begin
                wait_start("t1_wait", 40, ok);
                check("t1_gap_cycle", cyc + 1, m + 2 + 5);
            end
            send_pkt(15, m);
            check("t1_gen_stop", gen_stop, 1);
            check("t1_sent", sent_count, p + 1);
            check("t1_done", done, (p == 2));
        end
        step();
        check("t1_idle", busy, 0);
        check("t1_starts", starts - s0, 3);

        // continuous, gap 0, stop mid-packet
        s0 = starts;
        start_run(MODE_CONT, 0, 0);
        check("t2_start", gen_start, 1);
        for (int k = 0; k < 6; k++) begin
            mon_valid = 1'b1;
            mon_sop   = (k == 0);
            mon_eop   = (k == 5);
            cfg_stop  = (k == 2);
            step();
        end
        cfg_stop = 0; mon_valid = 0; mon_sop = 0; mon_eop = 0;
        check("t2_gen_stop", gen_stop, 1);
        check("t2_done", done, 1);
        check("t2_sent", sent_count, 1);
        repeat (10) step();
        check("t2_starts", starts - s0, 1);
        check("t2_idle", busy, 0);

        // single shot with MAC ready toggling
        s0 = starts;
        start_run(MODE_SINGLE, 5, 0);
        mon_rdy = 1'b0;
        b = 0;
        for (int i = 0; i < 40 && b < 4; i++) begin
            mon_valid = 1'b1;
            mon_sop   = (b == 0);
            mon_eop   = (b == 3);
            acc       = mon_rdy;
            last      = (b == 3);
            step();
            if (acc) b++;
            if (last && !acc) begin
                check("t3_unacc_sent", sent_count, 0);
                check("t3_unacc_stop", gen_stop, 0);
            end
            mon_rdy = ~mon_rdy;
        end
        mon_valid = 0; mon_sop = 0; mon_eop = 0; mon_rdy = 1;
        check("t3_beats", b, 4);
        check("t3_sent", sent_count, 1);
        check("t3_gen_stop", gen_stop, 1);
        check("t3_done", done, 1);
        repeat (5) step();
        check("t3_starts", starts - s0, 1);
        check("t3_idle", busy, 0);

        // burst count 0, then start+stop together
        s0 = starts;
        start_run(MODE_BURST, 0, 3);
        check("t4_done", done, 1);
        check("t4_no_start", gen_start, 0);
        check("t4_busy", busy, 0);
        check("t4_sent_clr", sent_count, 0);
        cfg_stop = 1'b1;
        start_run(MODE_BURST, 2, 0);
        cfg_stop = 1'b0;
        check("t4b_start", gen_start, 0);
        check("t4b_busy", busy, 0);
        check("t4b_done", done, 0);
        repeat (3) step();
        check("t4_starts", starts - s0, 0);

        // watchdog with no SOP
        start_run(MODE_SINGLE, 1, 0);
        check("t5_start", gen_start, 1);
        n = 0;
        while (!done && n < WDOG + 50) begin
            step();
            n++;
        end
        check("t5_latency", n, WDOG);
        check("t5_err_to", err_timeout, 1);
        check("t5_gen_stop", gen_stop, 1);
        check("t5_busy", busy, 0);
        step();
        check("t5_done_pulse", done, 0);
        check("t5_sticky", err_timeout, 1);
        start_run(MODE_BURST, 1, 0);
        check("t5_clear", err_timeout, 0);

        // double SOP, then reset while in GAP
        mon_valid = 1; mon_sop = 1; mon_eop = 0;
        step();
        check("t6_sop1", err_proto, 0);
        step();
        check("t6_sop2", err_proto, 1);
        mon_sop = 0; mon_eop = 1;
        step();
        mon_valid = 0; mon_eop = 0;
        check("t6_done", done, 1);
        check("t6_sent", sent_count, 1);
        check("t6_sticky", err_proto, 1);
        start_run(MODE_CONT, 0, 10);
        check("t6_clear", err_proto, 0);
        send_pkt(2, m);
        check("t6_gen_stop", gen_stop, 1);
        repeat (2) step();
        check("t6_in_gap", busy, 1);
        reset = 1;
        step();
        reset = 0;
        check("t6r_gen_start", gen_start, 0);
        check("t6r_gen_stop", gen_stop, 0);
        check("t6r_busy", busy, 0);
        check("t6r_done", done, 0);
        check("t6r_sent", sent_count, 0);
        check("t6r_err_to", err_timeout, 0);
        check("t6r_err_pr", err_proto, 0);
        s0 = starts;
        repeat (15) step();
        check("t6r_starts", starts - s0, 0);

        check("start_stop_overlap", overlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
